// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: state encoding and default widths shared by the ADC capture engine.
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_e;
  localparam int DROP_CNT_W = 16;
  localparam int DEF_DATA_W = 9;
  localparam int DEF_GRP_LANES = 8;
endpackage

// File: rtl/adc_grp_trig.sv
// adc_grp_trig: lane-group mux, S1 sample register and any-lane >= threshold compare.
module adc_grp_trig #(
  parameter int NUM_LANES = 96,
  parameter int DATA_W = 9,
  parameter int GRP_LANES = 8,
  parameter int NGRP = NUM_LANES / GRP_LANES,
  parameter int SEL_W = NGRP > 1 ? $clog2(NGRP) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES*DATA_W-1:0] adc_data,
  input  logic [SEL_W-1:0]            sel,
  input  logic [DATA_W-1:0]           lvl,
  output logic [GRP_LANES*DATA_W-1:0] s1,
  output logic                        trig
);
  localparam int GW = GRP_LANES * DATA_W;
  logic [GW-1:0] grp;
  // Out-of-range selects read as zero rather than indexing past the bus.
  always_comb begin
    grp = '0;
    for (int g = 0; g < NGRP; g++) grp = sel == SEL_W'(g) ? adc_data[g*GW +: GW] : grp;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else s1 <= grp;
  end
  always_comb begin
    trig = 1'b0;
    for (int l = 0; l < GRP_LANES; l++) trig = trig | (s1[l*DATA_W +: DATA_W] >= lvl);
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: captures one ADC lane group into SRAM, optionally after a level trigger.
// Define ADC_CAPTURE_TRIG_TIMEOUT_EN to add the ARMED-state trigger timeout.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int NUM_LANES = 96,
  parameter int DATA_W = DEF_DATA_W,
  parameter int GRP_LANES = DEF_GRP_LANES,
  parameter int ADDR_W = 12,
  localparam int NGRP = NUM_LANES / GRP_LANES,
  localparam int SEL_W = NGRP > 1 ? $clog2(NGRP) : 1
) (
  input  logic                        clk500m,
  input  logic                        rst_n,
  input  logic [NUM_LANES*DATA_W-1:0] adc_data,
  input  logic                        start,
  input  logic                        abort,
  input  logic [SEL_W-1:0]            grp_sel,
  input  logic                        trig_en,
  input  logic [DATA_W-1:0]           trig_level,
  input  logic [ADDR_W:0]             cap_len,
`ifdef ADC_CAPTURE_TRIG_TIMEOUT_EN
  input  logic [15:0]                 trig_timeout,
  output logic                        timed_out,
`endif
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [GRP_LANES*DATA_W-1:0] mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  cap_state_e state;
  logic [GRP_LANES*DATA_W-1:0] s1;
  logic trig, go, acc;
  logic [SEL_W-1:0] sel_q;
  logic [DATA_W-1:0] lvl_q;
  logic [ADDR_W:0] len_q, len_in;
`ifdef ADC_CAPTURE_TRIG_TIMEOUT_EN
  logic [15:0] tcnt;
`endif
  // The START cycle already muxes the new group so S1 is valid on the first ARMED/CAPTURE edge.
  always_comb begin
    go = start & ~abort & (state == IDLE || state == DONE);
    acc = mem_valid & mem_ready;
    len_in = cap_len == '0 ? (ADDR_W+1)'(1) : cap_len > MAX_LEN ? MAX_LEN : cap_len;
  end
  adc_grp_trig #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .GRP_LANES(GRP_LANES)) u_grp (
    .clk(clk500m),
    .rst_n(rst_n),
    .adc_data(adc_data),
    .sel(go ? grp_sel : sel_q),
    .lvl(lvl_q),
    .s1(s1),
    .trig(trig)
  );
  // mem_addr doubles as the accepted-word counter; it is not advanced on the final accept.
  always_ff @(posedge clk500m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= '0;
      lvl_q <= '0;
      len_q <= '0;
      mem_valid <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      drop_cnt <= '0;
`ifdef ADC_CAPTURE_TRIG_TIMEOUT_EN
      tcnt <= '0;
      timed_out <= 1'b0;
`endif
    end else if (abort) begin
      state <= IDLE;
      mem_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= trig_en ? ARMED : CAPTURE;
          sel_q <= grp_sel;
          lvl_q <= trig_level;
          len_q <= len_in;
          mem_addr <= '0;
          drop_cnt <= '0;
          busy <= 1'b1;
          done <= 1'b0;
`ifdef ADC_CAPTURE_TRIG_TIMEOUT_EN
          tcnt <= '0;
          timed_out <= 1'b0;
`endif
        end
        ARMED: if (trig) begin
          state <= CAPTURE;
          mem_valid <= 1'b1;
          mem_wdata <= s1;
        end
`ifdef ADC_CAPTURE_TRIG_TIMEOUT_EN
        else if (trig_timeout != '0 && tcnt == trig_timeout - 16'd1) begin
          state <= CAPTURE;
          mem_valid <= 1'b1;
          mem_wdata <= s1;
          timed_out <= 1'b1;
        end else tcnt <= tcnt + 16'd1;
`endif
        CAPTURE: if (acc && {1'b0, mem_addr} + 1'b1 == len_q) begin
          state <= DONE;
          mem_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          mem_valid <= 1'b1;
          mem_wdata <= s1;
          if (acc) mem_addr <= mem_addr + 1'b1;
          else if (mem_valid && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed and randomized checks of adc_capture_ctrl against a behavioural model.
module tb_adc_capture_ctrl;
  localparam int NL = 96, DW = 9, GL = 8, AW = 12, GW = GL * DW, SW = 4;
  logic clk500m = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, trig_en = 1'b0, mem_ready = 1'b0;
  logic [NL*DW-1:0] adc_data = '0;
  logic [SW-1:0] grp_sel = '0;
  logic [DW-1:0] trig_level = '0;
  logic [AW:0] cap_len = '0;
  logic mem_valid, busy, done;
  logic [AW-1:0] mem_addr;
  logic [GW-1:0] mem_wdata;
  logic [15:0] drop_cnt;
  int checks = 0, failures = 0;
  logic m_run = 1'b0, m_pres = 1'b0, m_ten = 1'b0;
  int m_sel = 0, m_lvl = 0, m_len = 1, m_acc = 0, m_drops = 0;
  logic [NL*DW-1:0] a_km1 = '0, a_k = '0;
  int n_wr = 0, first_addr = -1, last_addr = -1;
  logic [GW-1:0] first_w = '0;
  logic [9:0] pat = 10'b1101101011;

  always #5 clk500m = ~clk500m;

  adc_capture_ctrl dut (
    .clk500m(clk500m), .rst_n(rst_n), .adc_data(adc_data), .start(start), .abort(abort),
    .grp_sel(grp_sel), .trig_en(trig_en), .trig_level(trig_level), .cap_len(cap_len),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [GW-1:0] grp(input logic [NL*DW-1:0] a, input int s);
    return a[s*GW +: GW];
  endfunction

  function automatic logic any_ge(input logic [GW-1:0] w, input int lv);
    for (int l = 0; l < GL; l++) if (int'(w[l*DW +: DW]) >= lv) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NL*DW-1:0] rnd_bus();
    logic [NL*DW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*DW +: DW] = DW'($urandom_range(0, 511));
    return b;
  endfunction

  function automatic logic [NL*DW-1:0] ramp_bus(input int r);
    logic [NL*DW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*DW +: DW] = DW'((r + l) % 512);
    return b;
  endfunction

  function automatic logic [NL*DW-1:0] lane5(input int v);
    logic [NL*DW-1:0] b;
    b = '0;
    b[5*DW +: DW] = DW'(v);
    return b;
  endfunction

  // Called at each falling edge: check outputs of the last rising edge, then drive and advance the model.
  task automatic cyc(input logic st, input logic ab, input logic rdy, input logic [NL*DW-1:0] a);
    logic ev;
    ev = m_run && m_pres && m_acc < m_len;
    chk("valid", mem_valid, ev);
    chk("busy", busy, m_run && m_acc < m_len);
    chk("done", done, m_run && m_acc >= m_len);
    chk("drop_cnt", drop_cnt, m_drops);
    if (ev) begin
      chk("wdata", mem_wdata, grp(a_km1, m_sel));
      chk("addr", mem_addr, m_acc);
      if (rdy) begin
        if (n_wr == 0) begin
          first_w = mem_wdata;
          first_addr = int'(mem_addr);
        end
        n_wr++;
        last_addr = int'(mem_addr);
      end
    end else if (m_run && m_acc >= m_len) chk("final_addr", mem_addr, m_len - 1);
    start = st;
    abort = ab;
    mem_ready = rdy;
    adc_data = a;
    if (ab) begin
      m_run = 1'b0;
      m_pres = 1'b0;
    end else if (st && (!m_run || m_acc >= m_len)) begin
      m_run = 1'b1;
      m_pres = 1'b0;
      m_ten = trig_en;
      m_sel = int'(grp_sel);
      m_lvl = int'(trig_level);
      m_len = cap_len == 0 ? 1 : (cap_len > 4096 ? 4096 : int'(cap_len));
      m_acc = 0;
      m_drops = 0;
    end else if (m_run && m_acc < m_len) begin
      if (m_pres) begin
        if (rdy) m_acc++;
        else if (m_drops < 65535) m_drops++;
      end else if (!m_ten || any_ge(grp(a_k, m_sel), m_lvl)) m_pres = 1'b1;
    end
    a_km1 = a_k;
    a_k = a;
    @(negedge clk500m);
  endtask

  task automatic go(input int gs, input logic te, input int lv, input int ln, input logic [NL*DW-1:0] a);
    grp_sel = SW'(gs);
    trig_en = te;
    trig_level = DW'(lv);
    cap_len = (AW+1)'(ln);
    n_wr = 0;
    first_addr = -1;
    last_addr = -1;
    first_w = '0;
    cyc(1'b1, 1'b0, 1'b1, a);
  endtask

  initial begin
    @(negedge clk500m);
    @(negedge clk500m);
    chk("rst_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk500m);
    go(2, 1'b0, 0, 4, ramp_bus(10));
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, ramp_bus(10 + i));
    chk("t1_writes", n_wr, 4);
    chk("t1_first_lane16", first_w[DW-1:0], 26);
    chk("t1_last_addr", last_addr, 3);
    chk("t1_done", done, 1);
    chk("t1_drop", drop_cnt, 0);
    go(0, 1'b1, 'h100, 3, lane5('h0ff));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, lane5('h0ff));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, lane5('h100));
    chk("t2_first_lane5", first_w[5*DW +: DW], 'h100);
    chk("t2_first_addr", first_addr, 0);
    chk("t2_writes", n_wr, 3);
    go(5, 1'b0, 0, 7, rnd_bus());
    cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, pat[i], rnd_bus());
    cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    chk("t3_writes", n_wr, 7);
    chk("t3_drop", drop_cnt, 3);
    chk("t3_last_addr", last_addr, 6);
    chk("t3_done", done, 1);
    go(1, 1'b0, 0, 10, rnd_bus());
    cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    cyc(1'b0, 1'b1, 1'b1, rnd_bus());
    cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    chk("t4_writes", n_wr, 2);
    chk("t4_valid", mem_valid, 0);
    chk("t4_done", done, 0);
    go(3, 1'b0, 0, 2, rnd_bus());
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    chk("t4_restart_addr", first_addr, 0);
    chk("t4_restart_writes", n_wr, 2);
    go(7, 1'b0, 0, 0, rnd_bus());
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    chk("t5_len0_writes", n_wr, 1);
    go(11, 1'b0, 0, 4096, rnd_bus());
    for (int i = 0; i < 4100; i++) cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    chk("t5_max_writes", n_wr, 4096);
    chk("t5_max_last_addr", last_addr, 4095);
    chk("t5_max_done", done, 1);
    go(4, 1'b0, 0, 20, rnd_bus());
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, i[0], rnd_bus());
    rst_n = 1'b0;
    #1;
    chk("arst_valid", mem_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_addr", mem_addr, 0);
    m_run = 1'b0;
    m_pres = 1'b0;
    m_drops = 0;
    @(negedge clk500m);
    rst_n = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int ln, budget;
      ln = $urandom_range(0, 24);
      if ($urandom_range(0, 19) == 0) ln = $urandom_range(4090, 8191);
      go($urandom_range(0, 11), 1'($urandom_range(0, 1)), $urandom_range(0, 511), ln, rnd_bus());
      budget = 0;
      while (m_run && m_acc < m_len && budget < 6000) begin
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, rnd_bus());
        budget++;
      end
      if (m_run && m_acc < m_len) cyc(1'b0, 1'b1, 1'b1, rnd_bus());
      cyc(1'b0, 1'b0, 1'b1, rnd_bus());
      cyc(1'b0, 1'b0, 1'b1, rnd_bus());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
